// File: rtl/t03_mem_pkg.sv
// Shared types and lane helpers for the load/store memory handler.
// Holds the access-width encoding, the FSM state type and the byte-lane rules.
package t03_mem_pkg;

  typedef enum logic [2:0] {
    BYTE  = 3'b000,
    HALF  = 3'b001,
    WORD  = 3'b010,
    UBYTE = 3'b100,
    UHALF = 3'b101
  } datawidth_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mem_state_t;

  function automatic logic width_legal(input logic [2:0] w);
    case (w)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  // Bit 2 only selects signed/unsigned; bits [1:0] give the size.
  function automatic logic is_half(input logic [2:0] w);
    return (w[1:0] == 2'b01);
  endfunction

  function automatic logic is_word(input logic [2:0] w);
    return (w[1:0] == 2'b10);
  endfunction

  function automatic logic offset_aligned(input logic [2:0] w, input logic [1:0] off);
    if (is_word(w)) return (off == 2'b00);
    if (is_half(w)) return !off[0];
    return 1'b1;
  endfunction

  function automatic logic [3:0] lane_sel(input logic [2:0] w, input logic [1:0] off);
    if (is_word(w)) return 4'b1111;
    if (is_half(w)) return 4'b0011 << off;
    return 4'b0001 << off;
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] w, input logic [31:0] sd);
    if (is_word(w)) return sd;
    if (is_half(w)) return {2{sd[15:0]}};
    return {4{sd[7:0]}};
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Picks the addressed byte/halfword out of a bus read word and
// sign- or zero-extends it to 32 bits for register writeback.
module mem_load_extend
  import t03_mem_pkg::*;
(
  input  logic [1:0]  offset,
  input  datawidth_t  width,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    result = rdata;
    byte_v = rdata[{offset, 3'b000} +: 8];
    half_v = offset[1] ? rdata[31:16] : rdata[15:0];
    case (width)
      BYTE:    result = {{24{byte_v[7]}}, byte_v};
      UBYTE:   result = {24'h0, byte_v};
      HALF:    result = {{16{half_v[15]}}, half_v};
      UHALF:   result = {16'h0, half_v};
      WORD:    result = rdata;
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_handler.sv
// Data-memory side of load/store: one word-aligned bus transaction per request,
// core frozen until ack or timeout, load result extended for writeback.
module mem_handler
  import t03_mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [2:0]        dataWidth,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       storeData,
  output logic              freeze,
  output logic [31:0]       loadData,
  output logic              memErr,
  output logic              busRead,
  output logic              busWrite,
  output logic [ADDR_W-1:0] busAddr,
  output logic [31:0]       busWdata,
  output logic [3:0]        busSel,
  input  logic              busAck,
  input  logic [31:0]       busRdata
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t        state_q, state_d;
  logic              bus_read_q, bus_read_d;
  logic              bus_write_q, bus_write_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [3:0]        bus_sel_q, bus_sel_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        off_q, off_d;
  datawidth_t        width_q, width_d;
  logic              is_load_q, is_load_d;

  logic              req, legal_req, err_req, freeze_c;
  logic [31:0]       ext_data;

  mem_load_extend u_load_extend (
    .offset (off_q),
    .width  (width_q),
    .rdata  (busRdata),
    .result (ext_data)
  );

  assign req       = memRead ^ memWrite;
  assign legal_req = req && width_legal(dataWidth) && offset_aligned(dataWidth, addr[1:0]);
  assign err_req   = (memRead && memWrite) || (req && !legal_req);

  always_comb begin
    state_d     = state_q;
    bus_read_d  = bus_read_q;
    bus_write_d = bus_write_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d   = bus_sel_q;
    load_data_d = load_data_q;
    mem_err_d   = 1'b0;
    cnt_d       = cnt_q;
    off_d       = off_q;
    width_d     = width_q;
    is_load_d   = is_load_q;
    freeze_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (legal_req) begin
          freeze_c    = 1'b1;
          bus_read_d  = memRead;
          bus_write_d = memWrite;
          bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
          bus_sel_d   = lane_sel(dataWidth, addr[1:0]);
          bus_wdata_d = lane_data(dataWidth, storeData);
          off_d       = addr[1:0];
          width_d     = datawidth_t'(dataWidth);
          is_load_d   = memRead;
          cnt_d       = '0;
          state_d     = BUSY;
        end else if (err_req) begin
          mem_err_d   = 1'b1;
          load_data_d = 32'h0;
        end
      end

      BUSY: begin
        freeze_c = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        // An ack on the last allowed cycle still completes normally.
        if (busAck) begin
          if (is_load_q) load_data_d = ext_data;
          bus_read_d  = 1'b0;
          bus_write_d = 1'b0;
          state_d     = DONE;
        end else if (cnt_q == CNT_LAST) begin
          bus_read_d  = 1'b0;
          bus_write_d = 1'b0;
          mem_err_d   = 1'b1;
          load_data_d = 32'h0;
          state_d     = DONE;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!nrst) begin
      // NOTE: all of these are plain flops (no storage arrays), so each gets an explicit reset value.
      state_q     <= IDLE;
      bus_read_q  <= 1'b0;
      bus_write_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= 32'h0;
      bus_sel_q   <= 4'h0;
      load_data_q <= 32'h0;
      mem_err_q   <= 1'b0;
      cnt_q       <= '0;
      off_q       <= 2'b00;
      width_q     <= BYTE;
      is_load_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_read_q  <= bus_read_d;
      bus_write_q <= bus_write_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
      load_data_q <= load_data_d;
      mem_err_q   <= mem_err_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      width_q     <= width_d;
      is_load_q   <= is_load_d;
    end
  end

  // The core must never be stalled while held in reset.
  assign freeze   = nrst && freeze_c;
  assign loadData = load_data_q;
  assign memErr   = mem_err_q;
  assign busRead  = bus_read_q;
  assign busWrite = bus_write_q;
  assign busAddr  = bus_addr_q;
  assign busWdata = bus_wdata_q;
  assign busSel   = bus_sel_q;

endmodule
